hd44780_nybble_writer: RTL and testbench
========================================

Name: hd44780_nybble_writer

Overview:
- Bus-side consumer of the syscon's clock and reset; the initiator end of the HD44780 4-bit write interface.
- Takes byte writes from a controller over a strobe/ack handshake.
- Splits each byte into high then low nibble, generates E pulses, and times the LCD's execution delay before accepting the next byte.
- Optionally runs the HD44780 power-on 4-bit init sequence after reset.

Parameters:
- E_PULSE_CYCLES, 6: E high time per nibble (>=450 ns at 12 MHz).
- SHORT_WAIT_CYCLES, 480: post-byte wait, normal commands and data (>=37 us).
- LONG_WAIT_CYCLES, 19200: post-byte wait for clear/home, RS=0 and DAT in 0x01..0x03 (>=1.52 ms).
- POWERUP_CYCLES, 480000: initial wait after reset (>=40 ms); used only with INIT_SEQ_EN.
- INIT_WAIT1_CYCLES, 49200: wait after first 0x3 nibble (>=4.1 ms).
- INIT_WAIT2_CYCLES, 1200: wait after second 0x3 nibble (>=100 us).

Ports:
- CLK_I, in, 1: system clock, from syscon CLK_O.
- RST_I, in, 1: reset, synchronous, active-low.
- STB_I, in, 1: write request.
- RS_I, in, 1: register select for the request (0 = command, 1 = data).
- DAT_I, in, 8: byte to write.
- ACK_O, out, 1: one-cycle pulse when the request is accepted.
- BUSY_O, out, 1: high while the block cannot accept a request.
- LCD_RS_O, out, 1: LCD RS pin.
- LCD_RW_O, out, 1: LCD R/W pin; constant 0.
- LCD_E_O, out, 1: LCD enable pin.
- LCD_DB_O, out, 4: LCD DB7..DB4.

Behaviour:
- Reset (RST_I=0 at posedge):
  - Outputs: LCD_E_O=0, LCD_RS_O=0, LCD_DB_O=0, ACK_O=0, BUSY_O=1.
  - Internal: timer=0, latched byte=0.
  - Reset mid-pulse: E drops on that same edge; no partial nibble is completed.
- Timer:
  - Single down-counter, width $clog2 of the largest parameter + 1.
  - Loaded with N-1 on state entry; the state ends on the cycle the count reaches 0.
  - A parameter value of 0 is treated as 1.
- States:
  - PWRUP: wait out POWERUP_CYCLES.
  - INIT_NIB: send one nibble with RS=0.
  - INIT_WAIT: wait after an init nibble.
  - IDLE: ready for a request.
  - SETUP: E=0, RS and DB driven; 1 cycle.
  - E_HI: E=1; E_PULSE_CYCLES.
  - E_LO: E=0, RS/DB held; 1 cycle.
  - EXEC_WAIT: wait out the execution delay.
- Init sequence:
  - Order: PWRUP -> nibble 0x3 -> INIT_WAIT1 -> 0x3 -> INIT_WAIT2 -> 0x3 -> SHORT_WAIT -> 0x2 -> SHORT_WAIT -> IDLE.
  - Each nibble uses SETUP/E_HI/E_LO timing.
  - Function set and later commands are the client's job.
- IDLE:
  - BUSY_O=0.
  - STB_I=1 at an edge latches RS_I and DAT_I, goes to SETUP with the high nibble, and sets BUSY_O=1 and ACK_O=1 registered on that edge.
  - ACK_O returns to 0 on the next edge.
- Byte sequence:
  - High nibble: SETUP -> E_HI -> E_LO.
  - Low nibble: SETUP -> E_HI -> E_LO.
  - Then EXEC_WAIT, using LONG_WAIT_CYCLES when RS=0 and DAT<=0x03 and DAT!=0x00, otherwise SHORT_WAIT_CYCLES.
  - Then IDLE.
- Busy duration: BUSY_O stays high for exactly 2*(E_PULSE_CYCLES+2)+wait cycles after acceptance.
- Request rules:
  - STB_I while BUSY_O=1 (including during init) is ignored; no ACK, no latch. The client must hold STB_I until ACK_O.
  - STB_I held continuously produces back-to-back bytes, separated only by the wait time.
- Pin stability: LCD_DB_O and LCD_RS_O change only in SETUP entry, never while LCD_E_O=1. They keep their last values in IDLE.

Optional Feature:
- Macro: INIT_SEQ_EN.
- Defined: after reset the block enters PWRUP and runs the init sequence. BUSY_O stays 1 until the sequence completes.
- Undefined:
  - PWRUP, INIT_NIB and INIT_WAIT states are not built, and the POWERUP/INIT_WAIT parameters are unused.
  - After reset the block enters IDLE, with BUSY_O=0 on the first edge after RST_I returns to 1.

Test Plan:
(all with E_PULSE=2, SHORT=10, LONG=30, POWERUP=20, INIT1=15, INIT2=5)
- INIT_SEQ_EN defined, release reset -> 20 idle cycles, then E pulses on DB=0x3, 0x3, 0x3, 0x2 with gaps of 15, 5, 10 and 10 cycles; BUSY_O falls 10 cycles after the last E_LO.
- INIT_SEQ_EN undefined, STB_I=1, RS_I=1, DAT_I=0xA5 -> ACK_O one pulse; E pulses of 2 cycles each with DB=0xA then 0x5 and RS=1; BUSY_O high for 2*4+10=18 cycles.
- RS_I=0, DAT_I=0x01 -> EXEC_WAIT of 30 cycles; BUSY_O high for 38 cycles.
- RS_I=0, DAT_I=0x00 and DAT_I=0x04 -> short wait, 18 busy cycles.
- STB_I pulsed during BUSY_O=1 -> no ACK_O, no LCD activity. STB_I held for 3 bytes -> 3 ACKs spaced 19 cycles apart.
- RST_I=0 asserted while LCD_E_O=1 -> LCD_E_O=0 and BUSY_O=1 after that edge; after release, the block restarts from PWRUP (or IDLE when INIT_SEQ_EN is undefined).

Source files
------------

// File: rtl/hd44780_nybble_writer.sv
// Purpose: HD44780 4-bit write initiator; takes a byte over STB_I/ACK_O and sends high then low nibble with E pulses.
// Latency: ACK_O registered on the accepting edge; BUSY_O then stays high for 2*(E_PULSE_CYCLES+2)+exec-wait cycles.
// Backpressure: requests are taken only while BUSY_O=0; STB_I must be held until ACK_O, and ignored requests are not latched.
// Build option: define INIT_SEQ_EN to run the HD44780 power-on 4-bit init sequence after every reset.
module hd44780_nybble_writer #(
  parameter int unsigned E_PULSE_CYCLES    = 6,
  parameter int unsigned SHORT_WAIT_CYCLES = 480,
  parameter int unsigned LONG_WAIT_CYCLES  = 19200,
  parameter int unsigned POWERUP_CYCLES    = 480000,
  parameter int unsigned INIT_WAIT1_CYCLES = 49200,
  parameter int unsigned INIT_WAIT2_CYCLES = 1200
) (
  input  logic       CLK_I,
  input  logic       RST_I,
  input  logic       STB_I,
  input  logic       RS_I,
  input  logic [7:0] DAT_I,
  output logic       ACK_O,
  output logic       BUSY_O,
  output logic       LCD_RS_O,
  output logic       LCD_RW_O,
  output logic       LCD_E_O,
  output logic [3:0] LCD_DB_O
);

  // One down-counter serves every timed state, so it is sized for the largest delay.
  localparam int unsigned MAX_A = (E_PULSE_CYCLES > SHORT_WAIT_CYCLES) ? E_PULSE_CYCLES : SHORT_WAIT_CYCLES;
  localparam int unsigned MAX_B = (MAX_A > LONG_WAIT_CYCLES) ? MAX_A : LONG_WAIT_CYCLES;
  localparam int unsigned MAX_C = (MAX_B > POWERUP_CYCLES) ? MAX_B : POWERUP_CYCLES;
  localparam int unsigned MAX_D = (MAX_C > INIT_WAIT1_CYCLES) ? MAX_C : INIT_WAIT1_CYCLES;
  localparam int unsigned MAX_P = (MAX_D > INIT_WAIT2_CYCLES) ? MAX_D : INIT_WAIT2_CYCLES;
  localparam int          TW    = $clog2(MAX_P) + 1;

  typedef enum logic [2:0] {
`ifdef INIT_SEQ_EN
    PWRUP,
    INIT_NIB,
    INIT_WAIT,
`endif
    IDLE,
    SETUP,
    E_HI,
    E_LO,
    EXEC_WAIT
  } state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic [7:0]    byte_q;
  logic          rs_q;
  logic          low_nib;
`ifdef INIT_SEQ_EN
  logic          fresh;
  logic          in_init;
  logic [1:0]    init_step;
`endif

  // Timer load value for an N-cycle state; a zero-length request still lasts one cycle.
  function automatic logic [TW-1:0] ld(input int unsigned n);
    return (n == 0) ? '0 : TW'(n - 1);
  endfunction

`ifdef INIT_SEQ_EN
  // Wait that follows init nibble number step (0x3, 0x3, 0x3, 0x2).
  function automatic int unsigned init_wait(input logic [1:0] step);
    case (step)
      2'd0:    return INIT_WAIT1_CYCLES;
      2'd1:    return INIT_WAIT2_CYCLES;
      default: return SHORT_WAIT_CYCLES;
    endcase
  endfunction
`endif

  assign LCD_RW_O = 1'b0;

  // Sequencer: all pin and handshake outputs are registered here; DB/RS only move on SETUP/INIT_NIB entry.
  always_ff @(posedge CLK_I) begin
    if (!RST_I) begin
`ifdef INIT_SEQ_EN
      state     <= PWRUP;
      fresh     <= 1'b1;
      in_init   <= 1'b1;
      init_step <= 2'd0;
`else
      state     <= IDLE;
`endif
      timer    <= '0;
      byte_q   <= 8'h00;
      rs_q     <= 1'b0;
      low_nib  <= 1'b0;
      ACK_O    <= 1'b0;
      BUSY_O   <= 1'b1;
      LCD_E_O  <= 1'b0;
      LCD_RS_O <= 1'b0;
      LCD_DB_O <= 4'h0;
    end else begin
      ACK_O <= 1'b0;
      if (timer != '0) timer <= timer - 1'b1;
      case (state)
`ifdef INIT_SEQ_EN
        PWRUP: begin
          // The first edge out of reset arms the power-up delay.
          if (fresh) begin
            fresh <= 1'b0;
            timer <= ld(POWERUP_CYCLES);
          end else if (timer == '0) begin
            state    <= INIT_NIB;
            LCD_RS_O <= 1'b0;
            LCD_DB_O <= 4'h3;
          end
        end
        INIT_WAIT: begin
          if (timer == '0) begin
            if (init_step == 2'd3) begin
              in_init <= 1'b0;
              state   <= IDLE;
              BUSY_O  <= 1'b0;
            end else begin
              init_step <= init_step + 2'd1;
              state     <= INIT_NIB;
              LCD_DB_O  <= (init_step == 2'd2) ? 4'h2 : 4'h3;
            end
          end
        end
        INIT_NIB,
`endif
        SETUP: begin
          state   <= E_HI;
          LCD_E_O <= 1'b1;
          timer   <= ld(E_PULSE_CYCLES);
        end
        E_HI: begin
          if (timer == '0) begin
            state   <= E_LO;
            LCD_E_O <= 1'b0;
          end
        end
        E_LO: begin
`ifdef INIT_SEQ_EN
          if (in_init) begin
            state <= INIT_WAIT;
            timer <= ld(init_wait(init_step));
          end else
`endif
          if (!low_nib) begin
            state    <= SETUP;
            low_nib  <= 1'b1;
            LCD_DB_O <= byte_q[3:0];
          end else begin
            state <= EXEC_WAIT;
            // Clear display / return home need the long execution time.
            if (!rs_q && byte_q != 8'h00 && byte_q <= 8'h03)
              timer <= ld(LONG_WAIT_CYCLES);
            else
              timer <= ld(SHORT_WAIT_CYCLES);
          end
        end
        EXEC_WAIT: begin
          if (timer == '0) begin
            state  <= IDLE;
            BUSY_O <= 1'b0;
          end
        end
        IDLE: begin
          // BUSY_O is still high here only on the first edge after reset; that edge just makes the block ready.
          if (BUSY_O) begin
            BUSY_O <= 1'b0;
          end else if (STB_I) begin
            byte_q   <= DAT_I;
            rs_q     <= RS_I;
            low_nib  <= 1'b0;
            LCD_RS_O <= RS_I;
            LCD_DB_O <= DAT_I[7:4];
            ACK_O    <= 1'b1;
            BUSY_O   <= 1'b1;
            state    <= SETUP;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hd44780_nybble_writer.sv
// Bench for hd44780_nybble_writer: directed vector table, hand-written corner sequences, and random traffic
// checked every cycle against a queue-based model of the expected pin waveform.
// Honours INIT_SEQ_EN the same way as the design.
module tb_hd44780_nybble_writer;

  localparam int unsigned EP = 2, SW = 10, LW = 30, PU = 20, I1 = 15, I2 = 5;
  localparam int BUSY_S    = 2 * (EP + 2) + SW;
  localparam int BUSY_L    = 2 * (EP + 2) + LW;
  localparam int INIT_BUSY = PU + 4 * (EP + 2) + I1 + I2 + SW + SW;

  logic       CLK_I, RST_I, STB_I, RS_I;
  logic [7:0] DAT_I;
  logic       ACK_O, BUSY_O, LCD_RS_O, LCD_RW_O, LCD_E_O;
  logic [3:0] LCD_DB_O;

  hd44780_nybble_writer #(
    .E_PULSE_CYCLES(EP), .SHORT_WAIT_CYCLES(SW), .LONG_WAIT_CYCLES(LW),
    .POWERUP_CYCLES(PU), .INIT_WAIT1_CYCLES(I1), .INIT_WAIT2_CYCLES(I2)
  ) dut (
    .CLK_I(CLK_I), .RST_I(RST_I), .STB_I(STB_I), .RS_I(RS_I), .DAT_I(DAT_I),
    .ACK_O(ACK_O), .BUSY_O(BUSY_O), .LCD_RS_O(LCD_RS_O), .LCD_RW_O(LCD_RW_O),
    .LCD_E_O(LCD_E_O), .LCD_DB_O(LCD_DB_O)
  );

  initial CLK_I = 1'b0;
  always #5 CLK_I = ~CLK_I;

  typedef struct packed {
    logic       ack;
    logic       busy;
    logic       e;
    logic       rs;
    logic [3:0] db;
  } pins_t;

  typedef struct {
    logic       rs;
    logic [7:0] dat;
    int         busy;
  } vec_t;

  pins_t q[$];
  pins_t exp_p;
  bit    m_fresh;
  int    n_checks, n_errors, cyc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got 0x%0h, want 0x%0h", name, cyc, act, exp);
    end
  endtask

  function automatic pins_t mk(input logic a, input logic b, input logic e, input logic rs, input logic [3:0] db);
    return {a, b, e, rs, db};
  endfunction

  // One nibble transfer: setup cycle, EP cycles of E high, one hold cycle.
  task automatic push_nib(input logic rs, input logic [3:0] nib, input logic first_ack);
    q.push_back(mk(first_ack, 1'b1, 1'b0, rs, nib));
    for (int k = 0; k < int'(EP); k++) q.push_back(mk(1'b0, 1'b1, 1'b1, rs, nib));
    q.push_back(mk(1'b0, 1'b1, 1'b0, rs, nib));
  endtask

  task automatic push_wait(input int unsigned n, input logic rs, input logic [3:0] nib);
    for (int k = 0; k < int'(n); k++) q.push_back(mk(1'b0, 1'b1, 1'b0, rs, nib));
  endtask

  task automatic push_byte(input logic rs, input logic [7:0] dat);
    int unsigned w;
    w = (!rs && dat >= 8'd1 && dat <= 8'd3) ? LW : SW;
    push_nib(rs, dat[7:4], 1'b1);
    push_nib(rs, dat[3:0], 1'b0);
    push_wait(w, rs, dat[3:0]);
  endtask

`ifdef INIT_SEQ_EN
  task automatic push_init();
    push_wait(PU, 1'b0, 4'h0);
    push_nib(1'b0, 4'h3, 1'b0); push_wait(I1, 1'b0, 4'h3);
    push_nib(1'b0, 4'h3, 1'b0); push_wait(I2, 1'b0, 4'h3);
    push_nib(1'b0, 4'h3, 1'b0); push_wait(SW, 1'b0, 4'h3);
    push_nib(1'b0, 4'h2, 1'b0); push_wait(SW, 1'b0, 4'h2);
  endtask
`endif

  // Reference model: expected pins after this edge, from the inputs presented at it.
  task automatic model_step();
    if (!RST_I) begin
      q.delete();
      m_fresh = 1'b1;
      exp_p   = mk(1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
    end else if (q.size() > 0) begin
      exp_p = q.pop_front();
    end else if (m_fresh) begin
      m_fresh = 1'b0;
`ifdef INIT_SEQ_EN
      push_init();
      exp_p = q.pop_front();
`else
      exp_p.ack  = 1'b0;
      exp_p.busy = 1'b0;
`endif
    end else if (!exp_p.busy && STB_I) begin
      push_byte(RS_I, DAT_I);
      exp_p = q.pop_front();
    end else begin
      exp_p.ack  = 1'b0;
      exp_p.busy = 1'b0;
      exp_p.e    = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge CLK_I);
    model_step();
    cyc++;
    #1;
    chk("pins", {23'd0, LCD_RW_O, ACK_O, BUSY_O, LCD_E_O, LCD_RS_O, LCD_DB_O}, {24'd0, exp_p});
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 200 && BUSY_O; k++) tick();
    chk("idle_timeout", BUSY_O, 1'b0);
  endtask

  // First edges after reset release: init sequence or immediate readiness.
  task automatic startup();
`ifdef INIT_SEQ_EN
    int n;
    logic [15:0] nibs;
    logic prev;
    n = 0; nibs = 16'h0; prev = 1'b0;
    tick();
    while (BUSY_O && n < 400) begin
      n++;
      if (LCD_E_O && !prev) nibs = {nibs[11:0], LCD_DB_O};
      prev = LCD_E_O;
      tick();
    end
    chk("init_busy_len", n, INIT_BUSY);
    chk("init_nibbles", nibs, 16'h3332);
`else
    tick();
    chk("idle_after_rst", BUSY_O, 1'b0);
`endif
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[8];
    int n, ncnt, na, ne;
    int at[3];
    logic [7:0] nibs;
    logic prev, rs_ok;

    n_checks = 0; n_errors = 0; cyc = 0;
    m_fresh = 1'b1; exp_p = '0;
    RST_I = 1'b0; STB_I = 1'b0; RS_I = 1'b0; DAT_I = 8'h00;

    vt[0] = '{1'b1, 8'hA5, BUSY_S};
    vt[1] = '{1'b0, 8'h01, BUSY_L};
    vt[2] = '{1'b0, 8'h00, BUSY_S};
    vt[3] = '{1'b0, 8'h04, BUSY_S};
    vt[4] = '{1'b0, 8'h02, BUSY_L};
    vt[5] = '{1'b0, 8'h03, BUSY_L};
    vt[6] = '{1'b1, 8'h01, BUSY_S};
    vt[7] = '{1'b0, 8'hFF, BUSY_S};

    repeat (3) tick();
    chk("rst_e", LCD_E_O, 1'b0);
    chk("rst_busy", BUSY_O, 1'b1);
    chk("rst_ack", ACK_O, 1'b0);
    chk("rst_db", LCD_DB_O, 4'h0);
    chk("rst_rs", LCD_RS_O, 1'b0);

    RST_I = 1'b1;
    startup();

    // Directed byte table: busy length, nibble order and RS at each E pulse.
    for (int i = 0; i < 8; i++) begin
      wait_idle();
      STB_I = 1'b1; RS_I = vt[i].rs; DAT_I = vt[i].dat;
      tick();
      chk("ack", ACK_O, 1'b1);
      STB_I = 1'b0; RS_I = 1'($urandom); DAT_I = 8'($urandom);
      n = 0; ncnt = 0; nibs = 8'h00; prev = 1'b0; rs_ok = 1'b1;
      while (BUSY_O && n < 200) begin
        n++;
        if (LCD_E_O && !prev) begin
          nibs = {nibs[3:0], LCD_DB_O};
          ncnt++;
          if (LCD_RS_O !== vt[i].rs) rs_ok = 1'b0;
        end
        prev = LCD_E_O;
        tick();
      end
      chk("busy_len", n, vt[i].busy);
      chk("nibbles", nibs, vt[i].dat);
      chk("nib_cnt", ncnt, 2);
      chk("rs_at_e", rs_ok, 1'b1);
    end

    // Strobe pulsed while busy is ignored.
    wait_idle();
    STB_I = 1'b1; RS_I = 1'b0; DAT_I = 8'h38;
    tick();
    chk("ack_busy_seq", ACK_O, 1'b1);
    na = 0; ne = 0; prev = 1'b0;
    for (int k = 0; k < BUSY_S + 4; k++) begin
      STB_I = (k == 5 || k == 6);
      tick();
      if (ACK_O) na++;
      if (LCD_E_O && !prev) ne++;
      prev = LCD_E_O;
    end
    chk("busy_stb_acks", na, 0);
    chk("busy_stb_epulses", ne, 2);
    chk("busy_stb_idle", BUSY_O, 1'b0);

    // Strobe held: back-to-back bytes separated only by the wait.
    STB_I = 1'b1; RS_I = 1'b1; DAT_I = 8'h41;
    na = 0; at[0] = 0; at[1] = 0; at[2] = 0;
    for (int k = 0; k < 100 && na < 3; k++) begin
      tick();
      if (ACK_O) begin at[na] = cyc; na++; end
    end
    STB_I = 1'b0;
    chk("held_acks", na, 3);
    chk("ack_gap1", at[1] - at[0], BUSY_S + 1);
    chk("ack_gap2", at[2] - at[1], BUSY_S + 1);

    // Reset while E is high.
    wait_idle();
    STB_I = 1'b1; RS_I = 1'b1; DAT_I = 8'hC3;
    tick();
    STB_I = 1'b0;
    for (int k = 0; k < 20 && !LCD_E_O; k++) tick();
    chk("e_before_rst", LCD_E_O, 1'b1);
    RST_I = 1'b0;
    tick();
    chk("rst_mid_e", LCD_E_O, 1'b0);
    chk("rst_mid_busy", BUSY_O, 1'b1);
    RST_I = 1'b1;
    startup();

    // Random traffic with rare resets, checked every cycle by the model.
    for (int k = 0; k < 1500; k++) begin
      RST_I = ($urandom_range(0, 299) != 0);
      STB_I = ($urandom_range(0, 3) != 0);
      RS_I  = 1'($urandom);
      DAT_I = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 4)) : 8'($urandom);
      tick();
    end
    RST_I = 1'b1; STB_I = 1'b0;
    repeat (5) tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
